// File: rtl/cluster_accumulator_if.sv
`default_nettype none
// ============================================================================
//  Module   : cluster_accumulator_if
//  Brief    : Point-in / center-out handshake bundle for cluster_accumulator.
//  Revision : 1.0
// ============================================================================
interface cluster_accumulator_if #(
  parameter int DIM        = 3,
  parameter int DATA_RANGE = 255,
  parameter int K          = 4
);
  localparam int DIM_SIZE    = $clog2(DATA_RANGE);
  localparam int CENTER_SIZE = DIM * DIM_SIZE;
  localparam int ID_SIZE     = (K > 1) ? $clog2(K) : 1;

  logic                   in_valid;
  logic                   in_ready;
  logic [CENTER_SIZE-1:0] point;
  logic [ID_SIZE-1:0]     cluster_id;
  logic                   finalize;
  logic                   out_valid;
  logic                   out_ready;
  logic [ID_SIZE-1:0]     out_id;
  logic [CENTER_SIZE-1:0] out_center;
  logic                   out_empty;
  logic                   overflow;
  logic                   done;

  modport slave (
    input  in_valid, point, cluster_id, finalize, out_ready,
    output in_ready, out_valid, out_id, out_center, out_empty, overflow, done
  );

  modport master (
    output in_valid, point, cluster_id, finalize, out_ready,
    input  in_ready, out_valid, out_id, out_center, out_empty, overflow, done
  );
endinterface
`default_nettype wire

// File: rtl/cluster_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : cluster_accumulator
//  Brief    : Per-cluster sum/count accumulation with sequential mean division.
//             Optional CLUSTER_ACC_ROUND_EN selects round-half-up division.
//  Revision : 1.0
// ============================================================================
module cluster_accumulator #(
  parameter int DIM        = 3,
  parameter int DATA_RANGE = 255,
  parameter int K          = 4,
  parameter int MAX_POINTS = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  cluster_accumulator_if.slave  bus
);
  localparam int DIM_SIZE = $clog2(DATA_RANGE);
  localparam int ID_SIZE  = (K > 1) ? $clog2(K) : 1;
  localparam int CNT_SIZE = $clog2(MAX_POINTS + 1);
  localparam int SUM_SIZE = DIM_SIZE + CNT_SIZE;
`ifdef CLUSTER_ACC_ROUND_EN
  localparam int DIV_W    = SUM_SIZE + 1;
`else
  localparam int DIV_W    = SUM_SIZE;
`endif
  localparam int BIT_W    = $clog2(DIV_W);
  localparam int DIM_W    = (DIM > 1) ? $clog2(DIM) : 1;

  localparam logic [BIT_W-1:0]    LAST_BIT = BIT_W'(DIV_W - 1);
  localparam logic [DIM_W-1:0]    LAST_DIM = DIM_W'(DIM - 1);
  localparam logic [ID_SIZE-1:0]  LAST_ID  = ID_SIZE'(K - 1);
  localparam logic [CNT_SIZE-1:0] CNT_MAX  = CNT_SIZE'(MAX_POINTS);

  typedef enum logic [1:0] {
    ST_ACC = 2'd0,
    ST_DIV = 2'd1,
    ST_OUT = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [SUM_SIZE-1:0]            sum_q [K][DIM];
  logic [SUM_SIZE-1:0]            sum_d [K][DIM];
  logic [CNT_SIZE-1:0]            cnt_q [K];
  logic [CNT_SIZE-1:0]            cnt_d [K];
  logic [ID_SIZE-1:0]             c_q, c_d;
  logic [DIM_W-1:0]               d_q, d_d;
  logic [BIT_W-1:0]               bit_q, bit_d;
  logic [CNT_SIZE-1:0]            rem_q, rem_d;
  logic [DIV_W-1:0]               quo_q, quo_d;
  logic [DIM-1:0][DIM_SIZE-1:0]   center_q, center_d;
  logic                           empty_q, empty_d;
  logic                           overflow_q, overflow_d;
  logic                           done_q, done_d;

  logic [CNT_SIZE-1:0]            w_divisor;
  logic [DIV_W-1:0]               w_dividend;
  logic [DIV_W-1:0]               w_quo_src;
  logic [DIV_W-1:0]               w_quo_next;
  logic [CNT_SIZE-1:0]            w_rem_src;
  logic [CNT_SIZE:0]              w_shift;
  logic                           w_ge;
  logic [CNT_SIZE-1:0]            w_rem_next;
  logic [DIM_SIZE-1:0]            w_result;

  // One restoring-division step per cycle; the dividend is loaded on the first
  // step of each dimension so every dimension takes exactly DIV_W cycles.
  always_comb begin
    w_divisor  = cnt_q[c_q];
`ifdef CLUSTER_ACC_ROUND_EN
    w_dividend = DIV_W'(sum_q[c_q][d_q]) + DIV_W'(w_divisor >> 1);
`else
    w_dividend = sum_q[c_q][d_q];
`endif
    w_quo_src  = (bit_q == '0) ? w_dividend : quo_q;
    w_rem_src  = (bit_q == '0) ? '0 : rem_q;
    w_shift    = {w_rem_src, w_quo_src[DIV_W-1]};
    w_ge       = (w_shift >= {1'b0, w_divisor});
    w_rem_next = w_ge ? CNT_SIZE'(w_shift - {1'b0, w_divisor}) : w_shift[CNT_SIZE-1:0];
    w_quo_next = {w_quo_src[DIV_W-2:0], w_ge};
`ifdef CLUSTER_ACC_ROUND_EN
    w_result   = (w_quo_next > DIV_W'(DATA_RANGE)) ? DIM_SIZE'(DATA_RANGE)
                                                   : w_quo_next[DIM_SIZE-1:0];
`else
    w_result   = w_quo_next[DIM_SIZE-1:0];
`endif
  end

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    c_d        = c_q;
    d_d        = d_q;
    bit_d      = bit_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    center_d   = center_q;
    empty_d    = empty_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;

    case (state_q)
      ST_ACC: begin
        if (bus.in_valid && (int'(bus.cluster_id) < K)) begin
          if (cnt_q[bus.cluster_id] == CNT_MAX) begin
            overflow_d = 1'b1;
          end else begin
            cnt_d[bus.cluster_id] = cnt_q[bus.cluster_id] + 1'b1;
            for (int d = 0; d < DIM; d++) begin
              sum_d[bus.cluster_id][d] = sum_q[bus.cluster_id][d]
                                       + SUM_SIZE'(bus.point[d*DIM_SIZE +: DIM_SIZE]);
            end
          end
        end
        if (bus.finalize) begin
          state_d = ST_DIV;
          c_d     = '0;
          d_d     = '0;
          bit_d   = '0;
        end
      end

      ST_DIV: begin
        if (cnt_q[c_q] == '0) begin
          center_d = '0;
          empty_d  = 1'b1;
          state_d  = ST_OUT;
        end else begin
          empty_d = 1'b0;
          quo_d   = w_quo_next;
          rem_d   = w_rem_next;
          if (bit_q == LAST_BIT) begin
            center_d[d_q] = w_result;
            bit_d         = '0;
            if (d_q == LAST_DIM) begin
              d_d     = '0;
              state_d = ST_OUT;
            end else begin
              d_d = d_q + 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      ST_OUT: begin
        if (bus.out_ready) begin
          if (c_q == LAST_ID) begin
            // Last center delivered: wipe the iteration state for the next pass.
            for (int i = 0; i < K; i++) begin
              cnt_d[i] = '0;
              for (int d = 0; d < DIM; d++) begin
                sum_d[i][d] = '0;
              end
            end
            c_d      = '0;
            center_d = '0;
            empty_d  = 1'b0;
            done_d   = 1'b1;
            state_d  = ST_ACC;
          end else begin
            c_d     = c_q + 1'b1;
            state_d = ST_DIV;
          end
        end
      end

      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACC;
      for (int i = 0; i < K; i++) begin
        cnt_q[i] <= '0;
        for (int d = 0; d < DIM; d++) begin
          sum_q[i][d] <= '0;
        end
      end
      c_q        <= '0;
      d_q        <= '0;
      bit_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      center_q   <= '0;
      empty_q    <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      c_q        <= c_d;
      d_q        <= d_d;
      bit_q      <= bit_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      center_q   <= center_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign bus.in_ready   = (state_q == ST_ACC);
  assign bus.out_valid  = (state_q == ST_OUT);
  assign bus.out_id     = c_q;
  assign bus.out_center = center_q;
  assign bus.out_empty  = empty_q;
  assign bus.overflow   = overflow_q;
  assign bus.done       = done_q;

endmodule
`default_nettype wire
